pla_seq_eval: RTL

PLA_SEQ_EVAL -- requirements
Module: pla_seq_eval

---
 rtl/pla_seq_pkg.sv | 33 +++
 rtl/pla_cube_match.sv | 16 +
 rtl/pla_seq_eval.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pla_seq_pkg.sv
// Shared definitions for the sequential PLA evaluator: FSM state encoding,
// default geometry and the cube-table entry layout.
// Optional feature macro: PLA_SEQ_AUTOSYM_PROJ_EN (adds the PROJ state).
package pla_seq_pkg;

    localparam int PLA_N_IN_DEF    = 7;
    localparam int PLA_N_OUT_DEF   = 2;
    localparam int PLA_N_CUBES_DEF = 8;

`ifdef PLA_SEQ_AUTOSYM_PROJ_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROJ = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } state_t;
`endif

    // Cube entry at the default geometry; an entry whose out field is all
    // zero contributes nothing and is treated as invalid.
    typedef struct packed {
        logic [PLA_N_IN_DEF-1:0]  care;
        logic [PLA_N_IN_DEF-1:0]  val;
        logic [PLA_N_OUT_DEF-1:0] out;
    } cube_entry_t;

endpackage

// File: rtl/pla_cube_match.sv
// Combinational match of one cube against the evaluation vector: every
// cared-about bit of z must equal the corresponding bit of val.
module pla_cube_match
    import pla_seq_pkg::*;
#(
    parameter int N_IN = PLA_N_IN_DEF
) (
    input  logic [N_IN-1:0] z,
    input  logic [N_IN-1:0] care,
    input  logic [N_IN-1:0] val,
    output logic            match
);

    assign match = &((z ~^ val) | ~care);

endmodule

// File: rtl/pla_seq_eval.sv
// Sequential PLA evaluator: scans the cube table one entry per cycle using a
// single shared matcher and OR-accumulates the selected cube outputs.
// Optional feature macro: PLA_SEQ_AUTOSYM_PROJ_EN adds a GF(2) input
// projection matrix, its write port and a one-cycle PROJ state.
module pla_seq_eval
    import pla_seq_pkg::*;
#(
    parameter int N_IN    = PLA_N_IN_DEF,
    parameter int N_OUT   = PLA_N_OUT_DEF,
    parameter int N_CUBES = PLA_N_CUBES_DEF,
    localparam int AW     = (N_CUBES > 1) ? $clog2(N_CUBES) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef PLA_SEQ_AUTOSYM_PROJ_EN
    input  logic             proj_we,
    input  logic [((N_IN > 1) ? $clog2(N_IN) : 1)-1:0] proj_row,
    input  logic [N_IN-1:0]  proj_data,
`endif
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [N_IN-1:0]  cfg_care,
    input  logic [N_IN-1:0]  cfg_val,
    input  logic [N_OUT-1:0] cfg_out,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_y,
    output logic             busy
);

    typedef struct packed {
        logic [N_IN-1:0]  care;
        logic [N_IN-1:0]  val;
        logic [N_OUT-1:0] out;
    } cube_t;

    state_t           state_r;
    cube_t            cube_tab_r [N_CUBES];
    logic [AW-1:0]    idx_r;
    logic [N_IN-1:0]  z_r;
    logic [N_OUT-1:0] acc_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [N_OUT-1:0] out_y_r;
    logic             busy_r;
    logic             cfg_err_r;
    logic             cfg_ok_s;
    logic             cfg_bad_s;
    logic             proj_bad_s;
    logic             match_s;
    cube_t            cur_s;

`ifdef PLA_SEQ_AUTOSYM_PROJ_EN
    localparam int RW = (N_IN > 1) ? $clog2(N_IN) : 1;

    logic [N_IN-1:0] x_r;
    logic [N_IN-1:0] proj_r [N_IN];
    logic            proj_ok_s;

    // GF(2) inner product of one matrix row with the captured input.
    function automatic logic gf2_dot(input logic [N_IN-1:0] a, input logic [N_IN-1:0] b);
        return ^(a & b);
    endfunction
`endif

    assign cur_s = cube_tab_r[idx_r];

    pla_cube_match #(.N_IN(N_IN)) u_match (
        .z     (z_r),
        .care  (cur_s.care),
        .val   (cur_s.val),
        .match (match_s)
    );

    // Accept or reject a cube-table write: only from IDLE and only in range.
    always_comb begin
        cfg_ok_s  = 1'b0;
        cfg_bad_s = 1'b0;
        if (cfg_we) begin
            if ((state_r == ST_IDLE) && ({1'b0, cfg_addr} < (AW+1)'(N_CUBES))) begin
                cfg_ok_s = 1'b1;
            end else begin
                cfg_bad_s = 1'b1;
            end
        end else begin
            cfg_ok_s  = 1'b0;
            cfg_bad_s = 1'b0;
        end
    end

`ifdef PLA_SEQ_AUTOSYM_PROJ_EN
    // Accept or reject a projection-row write under the same rules.
    always_comb begin
        proj_ok_s  = 1'b0;
        proj_bad_s = 1'b0;
        if (proj_we) begin
            if ((state_r == ST_IDLE) && ({1'b0, proj_row} < (RW+1)'(N_IN))) begin
                proj_ok_s = 1'b1;
            end else begin
                proj_bad_s = 1'b1;
            end
        end else begin
            proj_ok_s  = 1'b0;
            proj_bad_s = 1'b0;
        end
    end

    // Projection matrix storage: identity after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < N_IN; r++) begin
                for (int j = 0; j < N_IN; j++) begin
                    proj_r[r][j] <= (r == j) ? 1'b1 : 1'b0;
                end
            end
        end else if (proj_ok_s) begin
            proj_r[proj_row] <= proj_data;
        end
    end
`else
    assign proj_bad_s = 1'b0;
`endif

    // Cube-table storage: all entries invalid after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < N_CUBES; c++) begin
                cube_tab_r[c].care <= {N_IN{1'b0}};
                cube_tab_r[c].val  <= {N_IN{1'b0}};
                cube_tab_r[c].out  <= {N_OUT{1'b0}};
            end
        end else if (cfg_ok_s) begin
            cube_tab_r[cfg_addr].care <= cfg_care;
            cube_tab_r[cfg_addr].val  <= cfg_val;
            cube_tab_r[cfg_addr].out  <= cfg_out;
        end
    end

    // One-cycle error pulse for any rejected configuration write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= cfg_bad_s | proj_bad_s;
        end
    end

    // Evaluation FSM: capture, optional projection, fixed-length scan, result hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_y_r     <= {N_OUT{1'b0}};
            busy_r      <= 1'b0;
            acc_r       <= {N_OUT{1'b0}};
            idx_r       <= {AW{1'b0}};
            z_r         <= {N_IN{1'b0}};
`ifdef PLA_SEQ_AUTOSYM_PROJ_EN
            x_r         <= {N_IN{1'b0}};
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        acc_r      <= {N_OUT{1'b0}};
                        idx_r      <= {AW{1'b0}};
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
`ifdef PLA_SEQ_AUTOSYM_PROJ_EN
                        x_r        <= in_x;
                        state_r    <= ST_PROJ;
`else
                        z_r        <= in_x;
                        state_r    <= ST_SCAN;
`endif
                    end else begin
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                    end
                end
`ifdef PLA_SEQ_AUTOSYM_PROJ_EN
                ST_PROJ: begin
                    for (int i = 0; i < N_IN; i++) begin
                        z_r[i] <= gf2_dot(proj_r[i], x_r);
                    end
                    state_r <= ST_SCAN;
                end
`endif
                ST_SCAN: begin
                    acc_r <= acc_r | (match_s ? cur_s.out : {N_OUT{1'b0}});
                    if (idx_r == AW'(N_CUBES - 1)) begin
                        state_r <= ST_DONE;
                    end else begin
                        idx_r <= idx_r + AW'(1'b1);
                    end
                end
                ST_DONE: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        out_y_r     <= acc_r;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_y     = out_y_r;
    assign busy      = busy_r;
    assign cfg_err   = cfg_err_r;

endmodule
